// File: rtl/apb_spi.sv
// APB-slave SPI master: two 32-bit TX/RX buffers, 1-4 byte transfers, modes 0-3, programmable SCLK divider.
// Optional feature macro: APB_SPI_LSB_FIRST_EN (CTRL[2] selects LSB-first shifting).
module apb_spi #(
  parameter int DIV_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  output logic        spi_clk,
  output logic        spi_dout,
  input  logic        spi_din,
  output logic        spi_cs,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  output logic [31:0] PRDATA,
  input  logic [31:0] PWDATA,
  input  logic [4:0]  PADDR
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_NEXT  = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_cpol, r_cpha, r_run_a, r_run_b, r_sel, r_cs, r_sclk, r_dout;
  logic [1:0]           r_len_a, r_len_b;
  logic [31:0]          r_txa, r_txb, r_rxa, r_rxb, r_sh;
  logic [DIV_WIDTH-1:0] r_div, r_div_cnt;
  logic [5:0]           r_edge;

  logic                 w_lsb, w_wr, w_busy, w_ld_b, w_lead, w_last, w_sample, w_unused;
  logic [1:0]           w_len, w_ld_len;
  logic [31:0]          w_ld_tx, w_ld_sh, w_rx_cur, w_rx_next;

`ifdef APB_SPI_LSB_FIRST_EN
  logic r_lsb;
  assign w_lsb = r_lsb;
`else
  assign w_lsb = 1'b0;
`endif

  function automatic logic [31:0] shift_out(input logic [31:0] sh, input logic lsb);
    shift_out = lsb ? {1'b0, sh[31:1]} : {sh[30:0], 1'b0};
  endfunction

  function automatic logic first_bit(input logic [31:0] sh, input logic lsb);
    first_bit = lsb ? sh[0] : sh[31];
  endfunction

  assign w_wr     = PSEL & PENABLE & PWRITE;
  assign w_busy   = r_run_a | r_run_b;
  assign w_unused = ^PADDR[1:0];

  // Buffer A always goes first; B is loaded only once RUN_A has cleared.
  assign w_ld_b   = ~r_run_a;
  assign w_ld_len = w_ld_b ? r_len_b : r_len_a;
  assign w_ld_tx  = w_ld_b ? r_txb : r_txa;
  assign w_ld_sh  = w_lsb ? w_ld_tx : (w_ld_tx << {~w_ld_len, 3'b000});

  assign w_len     = r_sel ? r_len_b : r_len_a;
  assign w_lead    = ~r_edge[0];
  assign w_last    = (r_edge == {w_len, 4'hF});
  assign w_sample  = w_lead ^ r_cpha;
  assign w_rx_cur  = r_sel ? r_rxb : r_rxa;
  assign w_rx_next = w_lsb ? ({1'b0, w_rx_cur[31:1]} | ({31'd0, spi_din} << {w_len, 3'b111}))
                           : {w_rx_cur[30:0], spi_din};

  assign spi_clk  = r_sclk;
  assign spi_dout = r_dout;
  assign spi_cs   = r_cs;

  // Register file, transfer FSM and SPI pin registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cpol    <= 1'b0;
      r_cpha    <= 1'b0;
      r_run_a   <= 1'b0;
      r_run_b   <= 1'b0;
      r_len_a   <= 2'd0;
      r_len_b   <= 2'd0;
      r_sel     <= 1'b0;
      r_cs      <= 1'b1;
      r_sclk    <= 1'b0;
      r_dout    <= 1'b0;
      r_txa     <= 32'd0;
      r_txb     <= 32'd0;
      r_rxa     <= 32'd0;
      r_rxb     <= 32'd0;
      r_sh      <= 32'd0;
      r_div     <= {DIV_WIDTH{1'b0}};
      r_div_cnt <= {DIV_WIDTH{1'b0}};
      r_edge    <= 6'd0;
`ifdef APB_SPI_LSB_FIRST_EN
      r_lsb     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_sclk <= r_cpol;
          if (w_busy) begin
            r_sel     <= w_ld_b;
            r_edge    <= 6'd0;
            r_div_cnt <= r_div;
            if (w_ld_b) r_rxb <= 32'd0;
            else        r_rxa <= 32'd0;
            // CPHA=0 must present the first bit before the leading edge.
            if (r_cpha) begin
              r_sh <= w_ld_sh;
            end else begin
              r_sh   <= shift_out(w_ld_sh, w_lsb);
              r_dout <= first_bit(w_ld_sh, w_lsb);
            end
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (r_div_cnt != {DIV_WIDTH{1'b0}}) begin
            r_div_cnt <= r_div_cnt - {{(DIV_WIDTH-1){1'b0}}, 1'b1};
          end else begin
            r_div_cnt <= r_div;
            r_sclk    <= ~r_sclk;
            r_edge    <= r_edge + 6'd1;
            if (w_sample) begin
              if (r_sel) r_rxb <= w_rx_next;
              else       r_rxa <= w_rx_next;
            end else if (!w_last) begin
              r_dout <= first_bit(r_sh, w_lsb);
              r_sh   <= shift_out(r_sh, w_lsb);
            end
            if (w_last) r_state <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (r_sel) r_run_b <= 1'b0;
          else       r_run_a <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_wr) begin
        if (PADDR[4:2] == 3'd3) begin
          r_cs <= PWDATA[0];
        end else if (!w_busy) begin
          case (PADDR[4:2])
            3'd0: begin
              r_cpol  <= PWDATA[0];
              r_cpha  <= PWDATA[1];
              r_run_a <= PWDATA[7];
              r_len_a <= PWDATA[9:8];
              r_run_b <= PWDATA[10];
              r_len_b <= PWDATA[12:11];
              r_sclk  <= PWDATA[0];
`ifdef APB_SPI_LSB_FIRST_EN
              r_lsb   <= PWDATA[2];
`endif
            end
            3'd1:    r_txa <= PWDATA;
            3'd4:    r_div <= PWDATA[DIV_WIDTH-1:0];
            3'd5:    r_txb <= PWDATA;
            default: ;
          endcase
        end
      end
    end
  end

  // APB read decode; unmapped addresses and idle bus read as zero.
  always_comb begin
    PRDATA = 32'd0;
    if (PSEL) begin
      case (PADDR[4:2])
        3'd0:    PRDATA = {19'd0, r_len_b, r_run_b, r_len_a, r_run_a, 4'd0, w_lsb, r_cpha, r_cpol};
        3'd1:    PRDATA = r_txa;
        3'd2:    PRDATA = r_rxa;
        3'd3:    PRDATA = {31'd0, r_cs};
        3'd4:    PRDATA = {{(32-DIV_WIDTH){1'b0}}, r_div};
        3'd5:    PRDATA = r_txb;
        3'd6:    PRDATA = r_rxb;
        default: PRDATA = 32'd0;
      endcase
    end else begin
      PRDATA = 32'd0;
    end
  end

endmodule

// File: tb/tb_apb_spi.sv
// Scoreboard bench for apb_spi: directed APB traffic with MOSI looped back to MISO.
module tb_apb_spi;

  localparam int K_APB  = 0;
  localparam int K_CS   = 1;
  localparam int K_SCLK = 2;
  localparam int K_DOUT = 3;
  localparam int K_CAP  = 4;
  localparam int K_CAPN = 5;
  localparam int K_PER  = 6;
  localparam int K_POLL = 7;

  typedef struct {
    int          kind;
    string       name;
    logic [63:0] exp;
    logic [63:0] mask;
  } sb_item_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_clk, spi_dout, spi_din, spi_cs;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PRDATA, PWDATA;
  logic [4:0]  PADDR;

  sb_item_t    sb[$];
  int          n_pass = 0;
  int          n_tot  = 0;
  int          cyc    = 0;
  logic        chk_rd = 1'b0;
  logic        done   = 1'b0;
  logic        poll_ok = 1'b0;
  logic        tb_cpol = 1'b0;
  logic        tb_cpha = 1'b0;
  logic [63:0] cap   = 64'd0;
  int          cap_n = 0;
  int          cap_base = 0;
  int          last_rise = 0;
  int          sclk_per = 0;

  assign spi_din = spi_dout;

  apb_spi #(.DIV_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .spi_clk(spi_clk), .spi_dout(spi_dout), .spi_din(spi_din), .spi_cs(spi_cs),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PRDATA(PRDATA), .PWDATA(PWDATA), .PADDR(PADDR)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record MOSI at every sampling edge of the programmed mode.
  always @(spi_clk) begin
    if ((spi_clk != tb_cpol) ^ tb_cpha) begin
      cap   = {cap[62:0], spi_dout};
      cap_n = cap_n + 1;
    end
  end

  always @(posedge spi_clk) begin
    sclk_per  = cyc - last_rise;
    last_rise = cyc;
  end

  task automatic push(input int kind, input string nm, input logic [63:0] e, input logic [63:0] m);
    sb_item_t it;
    it.kind = kind; it.name = nm; it.exp = e; it.mask = m;
    sb.push_back(it);
  endtask

  task automatic apb_write(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [4:0] a, input logic chk, output logic [31:0] d);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(posedge clk); #1;
    PENABLE = 1'b1; chk_rd = chk;
    @(negedge clk);
    d = PRDATA;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; chk_rd = 1'b0;
  endtask

  task automatic expect_reg(input string nm, input logic [4:0] a, input logic [31:0] e);
    logic [31:0] d;
    push(K_APB, nm, {32'd0, e}, 64'hFFFF_FFFF);
    apb_read(a, 1'b1, d);
  endtask

  task automatic expect_pin(input int kind, input string nm, input logic e);
    push(kind, nm, {63'd0, e}, 64'd1);
  endtask

  task automatic poll_idle(input string nm);
    logic [31:0] d;
    poll_ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      apb_read(5'h00, 1'b0, d);
      if ((d & 32'h0000_0480) == 32'd0) begin
        poll_ok = 1'b1;
        break;
      end
    end
    push(K_POLL, nm, 64'd1, 64'd1);
  endtask

  task automatic start_xfer(input logic [31:0] ctrl);
    tb_cpol = ctrl[0];
    tb_cpha = ctrl[1];
    apb_write(5'h00, ctrl);
    cap_base = cap_n;
  endtask

  task automatic expect_cap(input string nm, input int nbits, input logic [63:0] bits);
    logic [63:0] m;
    m = (nbits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << nbits) - 64'd1);
    push(K_CAP, nm, bits, m);
    push(K_CAPN, {nm, "_count"}, nbits, 64'hFFFF_FFFF_FFFF_FFFF);
  endtask

  // Scoreboard monitor: owns all pass/fail accounting.
  initial begin : monitor
    sb_item_t    it;
    logic [63:0] got;
    int          wait_cnt;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].kind != K_APB) begin
        it = sb.pop_front();
        case (it.kind)
          K_CS:    got = {63'd0, spi_cs};
          K_SCLK:  got = {63'd0, spi_clk};
          K_DOUT:  got = {63'd0, spi_dout};
          K_CAP:   got = cap;
          K_CAPN:  got = 64'(cap_n - cap_base);
          K_PER:   got = 64'(sclk_per);
          K_POLL:  got = {63'd0, poll_ok};
          default: got = 64'hDEAD;
        endcase
        n_tot++;
        if ((got & it.mask) == (it.exp & it.mask)) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", it.name, got & it.mask, it.exp & it.mask);
      end
      if (sb.size() > 0 && PSEL && PENABLE && !PWRITE && chk_rd) begin
        it  = sb.pop_front();
        got = {32'd0, PRDATA};
        n_tot++;
        if ((got & it.mask) == (it.exp & it.mask)) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", it.name, got, it.exp);
      end
      if (done) wait_cnt++;
      if (done && (sb.size() == 0 || wait_cnt > 20)) begin
        while (sb.size() > 0) begin
          it = sb.pop_front();
          n_tot++;
          $display("FAIL %s: no response, expected 0x%0h", it.name, it.exp);
        end
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
      end
      if (cyc > 80000) begin
        n_tot++;
        $display("FAIL watchdog: got cycle %0d expected completion before 80000", cyc);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
      end
    end
  end

  initial begin : stimulus
    reset = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 5'd0; PWDATA = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    expect_pin(K_CS, "rst_cs", 1'b1);
    expect_pin(K_SCLK, "rst_sclk", 1'b0);
    expect_pin(K_DOUT, "rst_dout", 1'b0);
    expect_reg("rst_ctrl", 5'h00, 32'd0);
    expect_reg("rst_txa", 5'h04, 32'd0);
    expect_reg("rst_rxb", 5'h18, 32'd0);
    expect_reg("rst_div", 5'h10, 32'd0);
    expect_reg("unmapped", 5'h1C, 32'd0);

    apb_write(5'h0C, 32'd0);
    expect_pin(K_CS, "cs_low", 1'b0);
    apb_write(5'h0C, 32'd1);
    expect_pin(K_CS, "cs_high", 1'b1);
    expect_reg("cs_reg", 5'h0C, 32'd1);

    // Mode 0, one byte on A.
    apb_write(5'h10, 32'd0);
    apb_write(5'h04, 32'h0000_00A5);
    start_xfer(32'h0000_0080);
    poll_idle("m0_poll");
    expect_reg("m0_rxa", 5'h08, 32'h0000_00A5);
    expect_reg("m0_ctrl", 5'h00, 32'h0000_0000);
    expect_cap("m0_mosi", 8, 64'h00A5);

    // Mode 1, one byte on A.
    start_xfer(32'h0000_0082);
    poll_idle("m1_poll");
    expect_reg("m1_rxa", 5'h08, 32'h0000_00A5);
    expect_cap("m1_mosi", 8, 64'h00A5);

    // Mode 1, buffer B only.
    apb_write(5'h14, 32'h0000_005A);
    start_xfer(32'h0000_0402);
    poll_idle("b_poll");
    expect_reg("b_rxb", 5'h18, 32'h0000_005A);
    expect_reg("b_ctrl", 5'h00, 32'h0000_0002);

    // Four bytes, DIV=3; writes while busy must be ignored except CS.
    apb_write(5'h10, 32'd3);
    apb_write(5'h04, 32'hFEED_ACA7);
    start_xfer(32'h0000_0380);
    apb_write(5'h04, 32'h1234_5678);
    apb_write(5'h10, 32'd0);
    apb_write(5'h00, 32'h0000_0000);
    apb_write(5'h0C, 32'd0);
    expect_pin(K_CS, "busy_cs", 1'b0);
    poll_idle("d3_poll");
    push(K_PER, "sclk_period", 64'd8, 64'hFFFF_FFFF_FFFF_FFFF);
    expect_reg("d3_rxa", 5'h08, 32'hFEED_ACA7);
    expect_reg("d3_txa_kept", 5'h04, 32'hFEED_ACA7);
    expect_reg("d3_div_kept", 5'h10, 32'd3);
    expect_reg("d3_ctrl", 5'h00, 32'h0000_0300);
    expect_cap("d3_mosi", 32, 64'hFEED_ACA7);
    apb_write(5'h0C, 32'd1);

    // Idle CPOL change, then back-to-back A and B in mode 3.
    tb_cpol = 1'b1; tb_cpha = 1'b1;
    apb_write(5'h00, 32'h0000_0003);
    expect_pin(K_SCLK, "cpol_idle", 1'b1);
    apb_write(5'h10, 32'd2);
    apb_write(5'h04, 32'hCA7B_17E5);
    apb_write(5'h14, 32'h0FEE_DCA7);
    start_xfer(32'h0000_1F83);
    poll_idle("ab_poll");
    expect_reg("ab_rxa", 5'h08, 32'hCA7B_17E5);
    expect_reg("ab_rxb", 5'h18, 32'h0FEE_DCA7);
    expect_reg("ab_ctrl", 5'h00, 32'h0000_1B03);
    expect_cap("ab_order", 64, 64'hCA7B_17E5_0FEE_DCA7);
    expect_pin(K_SCLK, "ab_sclk_idle", 1'b1);

    // Mode 2, two bytes: upper RX bits must be cleared.
    apb_write(5'h04, 32'hFFFF_1234);
    start_xfer(32'h0000_0181);
    poll_idle("m2_poll");
    expect_reg("m2_rxa", 5'h08, 32'h0000_1234);
    expect_reg("m2_ctrl", 5'h00, 32'h0000_0101);
    expect_cap("m2_mosi", 16, 64'h1234);

    // Reset in the middle of a transfer.
    apb_write(5'h0C, 32'd0);
    apb_write(5'h04, 32'hA5A5_A5A5);
    start_xfer(32'h0000_0381);
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    expect_pin(K_CS, "abort_cs", 1'b1);
    expect_pin(K_SCLK, "abort_sclk", 1'b0);
    expect_pin(K_DOUT, "abort_dout", 1'b0);
    expect_reg("abort_ctrl", 5'h00, 32'd0);
    expect_reg("abort_rxa", 5'h08, 32'd0);
    expect_reg("abort_txa", 5'h04, 32'd0);

    repeat (2) @(posedge clk);
    done = 1'b1;
  end

endmodule
